// File: rtl/pe_addr_gen.sv
// -----------------------------------------------------------------------------
// pe_addr_gen -- convolution window address generator
//
// A start pulse snapshots the layer geometry. The block then walks every output
// position (oy outer, ox) and every kernel tap (ky, kx fastest). For each tap it
// emits one input-buffer address over a valid/ready stream. Taps that fall into
// the padding border are flagged with pad_zero so the datapath can substitute
// a zero.
//
// Optional feature macro: PE_ADDR_GEN_CNT_EN
//   When it is defined, beat_count counts accepted beats since the last
//   accepted start and saturates at all-ones. When it is not defined,
//   beat_count is tied to 0.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle start pulse; ignored while busy
//   kernel_h/_w       kernel height / width (KH, KW)
//   input_h/_w        input height / width (H, W)
//   stride            stride S (0 is treated as 1)
//   padding           symmetric padding P
//   output_h/_w       output height / width (OH, OW)
//   addr_valid/ready  beat handshake
//   addr              input address iy*W+ix; 0 on padding taps
//   pad_zero          current tap lies in padding
//   win_last          current tap is the last one of its window
//   busy              high from start acceptance until completion
//   done              completion level; cleared by the next accepted start
//   beat_count        accepted beats since the last start (optional)
// -----------------------------------------------------------------------------
module pe_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        kernel_h,
  input  logic [3:0]        kernel_w,
  input  logic [7:0]        input_h,
  input  logic [7:0]        input_w,
  input  logic [3:0]        stride,
  input  logic [3:0]        padding,
  input  logic [7:0]        output_h,
  input  logic [7:0]        output_w,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              pad_zero,
  output logic              win_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  beat_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef struct packed {
    logic [3:0] kh;
    logic [3:0] kw;
    logic [7:0] ih;
    logic [7:0] iw;
    logic [3:0] s;
    logic [3:0] p;
    logic [7:0] oh;
    logic [7:0] ow;
  } geom_t;

  logic [1:0]        state_q, state_d;
  geom_t             geom_q, geom_d;
  logic [7:0]        oy_q, oy_d, ox_q, ox_d;
  logic [3:0]        ky_q, ky_d, kx_q, kx_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pad_q, pad_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  geom_t       geom_in, geom_sel;
  logic        start_acc, beat_acc, zero_geom;
  logic        kx_last, ky_last, ox_last, oy_last, run_end;
  logic [7:0]  nxt_oy, nxt_ox;
  logic [3:0]  nxt_ky, nxt_kx;
  logic [7:0]  t_oy, t_ox;
  logic [3:0]  t_ky, t_kx;
  logic [13:0] iy, ix;
  logic [15:0] tap_addr_full;
  logic        tap_pad, tap_last;
  logic [ADDR_W-1:0] tap_addr;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign beat_acc  = valid_q && addr_ready;
  assign zero_geom = (kernel_h == 4'd0) || (kernel_w == 4'd0) ||
                     (output_h == 8'd0) || (output_w == 8'd0);

  always_comb begin
    geom_in    = '0;
    geom_in.kh = kernel_h;
    geom_in.kw = kernel_w;
    geom_in.ih = input_h;
    geom_in.iw = input_w;
    geom_in.s  = (stride == 4'd0) ? 4'd1 : stride;
    geom_in.p  = padding;
    geom_in.oh = output_h;
    geom_in.ow = output_w;
  end

  // Wrap detection and index advance for the beat currently presented.
  assign kx_last = (kx_q == geom_q.kw - 4'd1);
  assign ky_last = (ky_q == geom_q.kh - 4'd1);
  assign ox_last = (ox_q == geom_q.ow - 8'd1);
  assign oy_last = (oy_q == geom_q.oh - 8'd1);
  assign run_end = kx_last && ky_last && ox_last && oy_last;

  assign nxt_kx = kx_last ? 4'd0 : kx_q + 4'd1;
  assign nxt_ky = kx_last ? (ky_last ? 4'd0 : ky_q + 4'd1) : ky_q;
  assign nxt_ox = (kx_last && ky_last) ? (ox_last ? 8'd0 : ox_q + 8'd1) : ox_q;
  assign nxt_oy = (kx_last && ky_last && ox_last) ? oy_q + 8'd1 : oy_q;

  // The tap to register next: the first tap on start, else the successor.
  // On start the geometry comes straight from the inputs because the snapshot
  // is only being written on this edge.
  assign geom_sel = start_acc ? geom_in : geom_q;
  assign t_oy     = start_acc ? 8'd0 : nxt_oy;
  assign t_ox     = start_acc ? 8'd0 : nxt_ox;
  assign t_ky     = start_acc ? 4'd0 : nxt_ky;
  assign t_kx     = start_acc ? 4'd0 : nxt_kx;

  // Two's-complement 14-bit indices: bit 13 set means the index went negative.
  // The magnitude never exceeds 255*15+15, so no overflow into the sign bit.
  assign iy = {6'd0, t_oy} * {10'd0, geom_sel.s} + {10'd0, t_ky} - {10'd0, geom_sel.p};
  assign ix = {6'd0, t_ox} * {10'd0, geom_sel.s} + {10'd0, t_kx} - {10'd0, geom_sel.p};

  assign tap_pad = iy[13] || ix[13] ||
                   (iy >= {6'd0, geom_sel.ih}) || (ix >= {6'd0, geom_sel.iw});

  // In-bounds indices are below 256, so only the low byte takes part.
  assign tap_addr_full = {8'd0, iy[7:0]} * {8'd0, geom_sel.iw} + {8'd0, ix[7:0]};
  assign tap_addr      = tap_pad ? '0 : ADDR_W'(tap_addr_full);
  assign tap_last      = (t_ky == geom_sel.kh - 4'd1) && (t_kx == geom_sel.kw - 4'd1);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    geom_d  = geom_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    pad_d   = pad_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          geom_d = geom_in;
          done_d = 1'b0;
          busy_d = 1'b1;
          oy_d   = 8'd0;
          ox_d   = 8'd0;
          ky_d   = 4'd0;
          kx_d   = 4'd0;
          if (zero_geom) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            addr_d  = tap_addr;
            pad_d   = tap_pad;
            last_d  = tap_last;
          end
        end
      end
      ST_RUN: begin
        if (beat_acc) begin
          if (run_end) begin
            valid_d = 1'b0;
            state_d = ST_FINISH;
          end else begin
            oy_d   = nxt_oy;
            ox_d   = nxt_ox;
            ky_d   = nxt_ky;
            kx_d   = nxt_kx;
            addr_d = tap_addr;
            pad_d  = tap_pad;
            last_d = tap_last;
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      geom_q  <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      pad_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      geom_q  <= geom_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      pad_q   <= pad_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign pad_zero   = pad_q;
  assign win_last   = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef PE_ADDR_GEN_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of accepted beats; holds after done until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_acc) begin
      cnt_q <= '0;
    end else if (beat_acc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign beat_count = cnt_q;
`else
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_pe_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_pe_addr_gen -- self-checking bench for pe_addr_gen.
// A table of geometries with hand-derived totals, full-stream comparison
// against a loop-nest reference model, random backpressure, a mid-run
// start/config/reset sequence and randomized geometries.
// -----------------------------------------------------------------------------
module tb_pe_addr_gen;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        kernel_h, kernel_w, stride, padding;
  logic [7:0]        input_h, input_w, output_h, output_w;
  logic              addr_valid, addr_ready;
  logic [ADDR_W-1:0] addr;
  logic              pad_zero, win_last, busy, done;
  logic [CNT_W-1:0]  beat_count;

  pe_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kernel_h   (kernel_h),
    .kernel_w   (kernel_w),
    .input_h    (input_h),
    .input_w    (input_w),
    .stride     (stride),
    .padding    (padding),
    .output_h   (output_h),
    .output_w   (output_w),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .pad_zero   (pad_zero),
    .win_last   (win_last),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  // Geometry plus hand-derived totals: beat count, padding-beat count and the
  // address / pad flag of the final beat.
  typedef struct {
    int kh, kw, h, w, s, p, oh, ow;
    int beats, pads, last_addr, last_pad;
  } vec_t;

  typedef struct {
    int addr;
    bit pad;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  vec_t  vecs[6];
  vec_t  rv;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: direct loop nest over output positions and taps.
  task automatic build_model(input vec_t v);
    int s, iy, ix;
    beat_t b;
    exp_q.delete();
    s = (v.s == 0) ? 1 : v.s;
    for (int oy = 0; oy < v.oh; oy++)
      for (int ox = 0; ox < v.ow; ox++)
        for (int ky = 0; ky < v.kh; ky++)
          for (int kx = 0; kx < v.kw; kx++) begin
            iy = oy * s + ky - v.p;
            ix = ox * s + kx - v.p;
            b.pad  = (iy < 0) || (iy >= v.h) || (ix < 0) || (ix >= v.w);
            b.addr = b.pad ? 0 : ((iy * v.w + ix) % 65536);
            b.last = (ky == v.kh - 1) && (kx == v.kw - 1);
            exp_q.push_back(b);
          end
  endtask

  task automatic set_cfg(input vec_t v);
    kernel_h = 4'(v.kh);
    kernel_w = 4'(v.kw);
    input_h  = 8'(v.h);
    input_w  = 8'(v.w);
    stride   = 4'(v.s);
    padding  = 4'(v.p);
    output_h = 8'(v.oh);
    output_w = 8'(v.ow);
  endtask

  // Returns at the falling edge just after the start-sampling edge.
  task automatic start_pulse(input vec_t v);
    @(negedge clk);
    set_cfg(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic cmp_beat(input int i);
    check("beat_addr", 32'(addr), 32'(exp_q[i].addr));
    check("beat_pad", 32'(pad_zero), 32'(exp_q[i].pad));
    check("beat_last", 32'(win_last), 32'(exp_q[i].last));
  endtask

  task automatic run_stream(input vec_t v, input bit rand_ready, input bit check_totals);
    int n, idx, cyc, budget, pads, last_a, last_p;
    bit stalled;
    logic [ADDR_W-1:0] h_addr;
    logic h_pad, h_last;
    build_model(v);
    n = exp_q.size();
    start_pulse(v);
    check("busy_after_start", 32'(busy), 1);
    check("done_clear_on_start", 32'(done), 0);
    idx = 0; cyc = 0; pads = 0; last_a = -1; last_p = -1; stalled = 0;
    h_addr = '0; h_pad = 1'b0; h_last = 1'b0;
    budget = 4 * n + 20;
    while (idx < n && cyc < budget) begin
      addr_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!rand_ready) check("no_bubble", 32'(addr_valid), 1);
      if (stalled) begin
        check("stall_valid", 32'(addr_valid), 1);
        check("stall_addr", 32'(addr), 32'(h_addr));
        check("stall_pad", 32'(pad_zero), 32'(h_pad));
        check("stall_last", 32'(win_last), 32'(h_last));
      end
      stalled = 0;
      if (addr_valid) begin
        if (addr_ready) begin
          cmp_beat(idx);
          pads += int'(pad_zero);
          last_a = int'(addr);
          last_p = int'(pad_zero);
          idx++;
        end else begin
          stalled = 1;
          h_addr = addr; h_pad = pad_zero; h_last = win_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("beats_accepted", 32'(idx), 32'(n));
    addr_ready = 1'b1;
    check("valid_drop", 32'(addr_valid), 0);
    check("finish_busy", 32'(busy), 1);
    check("finish_done", 32'(done), 0);
    @(negedge clk);
    check("done_level", 32'(done), 1);
    check("busy_clear", 32'(busy), 0);
`ifdef PE_ADDR_GEN_CNT_EN
    check("beat_count", beat_count, 32'(n));
`else
    check("beat_count_tied", beat_count, 0);
`endif
    if (check_totals) begin
      check("total_beats", 32'(idx), 32'(v.beats));
      check("total_pads", 32'(pads), 32'(v.pads));
      if (v.beats > 0) begin
        check("last_addr", 32'(last_a), 32'(v.last_addr));
        check("last_pad", 32'(last_p), 32'(v.last_pad));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc;
    rst = 1'b1;
    start = 1'b0;
    addr_ready = 1'b0;
    kernel_h = '0; kernel_w = '0; input_h = '0; input_w = '0;
    stride = '0; padding = '0; output_h = '0; output_w = '0;

    //          kh kw h  w  s  p  oh ow  beats pads last_addr last_pad
    vecs[0] = '{3, 3, 4, 4, 1, 0, 2, 2,  36,   0,   15,       0};
    vecs[1] = '{3, 3, 4, 4, 1, 1, 4, 4,  144,  44,  0,        1};
    vecs[2] = '{2, 2, 4, 4, 2, 0, 2, 2,  16,   0,   15,       0};
    vecs[3] = '{2, 2, 4, 4, 0, 0, 3, 3,  36,   0,   15,       0};
    vecs[4] = '{3, 0, 4, 4, 1, 0, 2, 2,  0,    0,   0,        0};
    vecs[5] = '{1, 2, 3, 5, 3, 2, 2, 3,  12,   9,   0,        1};

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(addr_valid), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_pad", 32'(pad_zero), 0);
    check("rst_last", 32'(win_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", beat_count, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_stream(vecs[i], 1'b0, 1'b1);

    // Random backpressure on the basic geometry.
    run_stream(vecs[0], 1'b1, 1'b1);

    // Start pulse and input_w change mid-run are ignored; reset aborts.
    build_model(vecs[0]);
    start_pulse(vecs[0]);
    addr_ready = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 10 && cyc < 100) begin
      start = 1'b0;
      if (addr_valid) begin
        cmp_beat(idx);
        idx++;
        if (idx == 5) begin
          start = 1'b1;
          input_w = 8'd8;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("midrun_beats", 32'(idx), 10);
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(addr_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    run_stream(vecs[0], 1'b0, 1'b1);

    // Randomized geometries under random backpressure.
    repeat (20) begin
      rv.kh = $urandom_range(1, 3);
      rv.kw = $urandom_range(1, 3);
      rv.h  = $urandom_range(1, 6);
      rv.w  = $urandom_range(1, 6);
      rv.s  = $urandom_range(0, 3);
      rv.p  = $urandom_range(0, 2);
      rv.oh = $urandom_range(1, 4);
      rv.ow = $urandom_range(1, 4);
      rv.beats = 0; rv.pads = 0; rv.last_addr = 0; rv.last_pad = 0;
      run_stream(rv, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_addr_gen.md
Name: pe_addr_gen

Overview:
Convolution window address generator sitting directly downstream of the PE configuration registers. A start pulse snapshots the layer geometry: kernel, input, stride, padding and output dimensions. The block then walks every output position and every kernel tap, emitting one input-buffer address per beat over a valid/ready stream to the PE datapath. Padding taps are flagged for zero-fill. A done level is fed back to the configuration block's status register.

Parameters:
ADDR_W, 16, width of emitted input-buffer address
CNT_W, 32, width of optional beat counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle start pulse from config block
kernel_h  in  4  kernel height KH
kernel_w  in  4  kernel width KW
input_h  in  8  input height H
input_w  in  8  input width W
stride  in  4  stride S; 0 treated as 1
padding  in  4  symmetric padding P
output_h  in  8  output height OH
output_w  in  8  output width OW
addr_valid  out  1  beat valid
addr_ready  in  1  downstream accepts beat
addr  out  ADDR_W  input address, row-major iy*W+ix
pad_zero  out  1  tap lies in padding; datapath substitutes 0
win_last  out  1  last tap (ky=KH-1, kx=KW-1) of current window
busy  out  1  high from start acceptance until completion
done  out  1  completion level
beat_count  out  CNT_W  accepted beats since last start (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: addr_valid, addr, pad_zero, win_last, busy, done and beat_count are all 0. State is IDLE.
- States:
  - IDLE: start=1 snapshots all config inputs, clears done, sets busy and moves to RUN. If any of KH, KW, OH or OW is 0, go to FINISH instead with no beats.
  - RUN: emits beats.
  - FINISH: lasts one cycle. Clears busy, sets done and returns to IDLE.
- Start while busy is ignored. Config input changes after the snapshot have no effect.
- Loop order is oy outer, then ox, then ky, with kx fastest. Total beats = OH*OW*KH*KW.
- First addr_valid is high in the cycle after the start cycle.
- Index arithmetic:
  - iy = oy*S + ky - P and ix = ox*S + kx - P, computed signed and at least 13 bits wide.
  - pad_zero=1 if iy<0, iy>=H, ix<0 or ix>=W. In that case addr=0.
  - Otherwise addr = iy*W + ix, truncated to ADDR_W.
- Handshake:
  - Beats advance only on addr_valid & addr_ready.
  - While stalled, addr, pad_zero and win_last hold stable and addr_valid stays high.
  - With ready held high, one beat per cycle with no bubbles.
- All outputs are registered.
- When the final beat is accepted, addr_valid drops the next cycle and the block enters FINISH. done rises the cycle after that.
- done stays high until the next accepted start. It clears in the same cycle start is sampled.
- Counter wrap: kx wraps to 0 and increments ky, ky wraps and increments ox, ox wraps and increments oy. Wrap of oy at OH ends the run.
- Reset mid-run aborts immediately. No partial state survives, and the next start begins at oy=ox=ky=kx=0.

Optional Feature:
Macro PE_ADDR_GEN_CNT_EN.
- Defined: beat_count clears on an accepted start and increments on each accepted beat. It saturates at all-ones and holds its value after done.
- Undefined: beat_count is tied to 0 and no counter logic is synthesized.

Test Plan:
1. KH=KW=3, H=W=4, S=1, P=0, OH=OW=2, ready=1 -> 36 beats, all pad_zero=0. First window addrs 0,1,2,4,5,6,8,9,10. win_last on beats 9/18/27/36. done=1 two cycles after beat 36. beat_count=36 with the macro, 0 without.
2. KH=KW=3, H=W=4, S=1, P=1, OH=OW=4 -> 144 beats. Beats 1–4 have pad_zero=1, addr=0. Beat 5 (ky=1, kx=1) has addr=0, pad_zero=0. Beat 9 has addr=5, pad_zero=0.
3. KH=KW=2, H=W=4, S=2, P=0, OH=OW=2 -> window first-tap addrs 0, 2, 8, 10; 16 beats. Also S=0 gives the same sequence as S=1 with matching dims.
4. Test 1 config with addr_ready toggling pseudo-randomly -> same 36-beat sequence. Outputs are stable across every stalled cycle and there are no dropped or duplicated beats.
5. Run test 1, pulse start after beat 5, change input_w to 8 mid-run -> both ignored and the sequence is unchanged. Then assert rst for one cycle after beat 10 -> addr_valid, busy and done drop immediately. A fresh start replays from addr 0.
6. KW=0 with start -> no addr_valid. busy is high for 1 cycle and done=1 two cycles after start. A subsequent start clears done in the sampling cycle.
